ring_count_monitor: RTL and testbench

//  Receive-side checker for a one-hot ring-counter bus. Samples q each enabled

---
 rtl/ring_pkg.sv | 48 ++++
 rtl/onehot_dec.sv | 17 +
 rtl/ring_count_monitor.sv | 142 ++++++++++++++
 tb/tb_ring_count_monitor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring counter and its monitor:
// state encodings, rotation helpers and a one-hot to index decoder.
package ring_pkg;

  // Widest ring the helper functions handle.
  localparam int MAX_N = 32;
  typedef logic [MAX_N-1:0] ring_vec_t;

  // Monitor state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  // Rotate the low n bits of v left by one (bit n-1 wraps to bit 0).
  function automatic ring_vec_t rot_left(input ring_vec_t v, input int n);
    ring_vec_t  r;
    logic [4:0] src;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      src = (i == 0) ? 5'(n - 1) : 5'(i - 1);
      if (i < n) r[i] = v[src];
    end
    return r;
  endfunction

  // Rotate the low n bits of v right by one (bit 0 wraps to bit n-1).
  function automatic ring_vec_t rot_right(input ring_vec_t v, input int n);
    ring_vec_t  r;
    logic [4:0] src;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      src = (i == n - 1) ? 5'd0 : 5'(i + 1);
      if (i < n) r[i] = v[src];
    end
    return r;
  endfunction

  // Index of the highest set bit; meaningful only when v is one-hot.
  function automatic logic [4:0] onehot_to_idx(input ring_vec_t v);
    logic [4:0] k;
    k = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) k = 5'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational decode of a ring bus: binary index of the hot bit and a
// flag that says whether exactly one bit is set.
module onehot_dec
  import ring_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  q,
  output logic [IW-1:0] idx,
  output logic          onehot
);

  assign onehot = ($countones(q) == 1);
  assign idx    = IW'(onehot_to_idx(MAX_N'(q)));

endmodule

// File: rtl/ring_count_monitor.sv
// Receive-side checker for a one-hot ring-counter bus: decodes the hot bit,
// checks legality and rotation against the previous sample, locks after a
// run of good steps and flags/counts violations seen while locked.
module ring_count_monitor
  import ring_pkg::*;
#(
  parameter int N        = 4,
  parameter int DIR      = 0,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic [N-1:0]     q,
  input  logic             clr_err,
  output logic [IW-1:0]    idx,
  output logic             valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [GW-1:0]    good_q, good_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic [IW-1:0]    dec_idx;
  logic             dec_onehot;
  logic [N-1:0]     exp_next;
  logic             match;
  logic [GW-1:0]    good_inc;

  onehot_dec #(.N(N), .IW(IW)) u_dec (
    .q      (q),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  // Expected successor of the previous sample and the rotation check.
  always_comb begin
    exp_next = (DIR == 0) ? N'(rot_left(MAX_N'(prev_q), N))
                          : N'(rot_right(MAX_N'(prev_q), N));
    match    = dec_onehot && (q == exp_next);
    good_inc = good_q + GW'(1);
  end

  // Next-state logic: FSM, previous sample, good-step counter, error count.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (en) begin
      valid_d = dec_onehot;
      if (dec_onehot) begin
        idx_d  = dec_idx;
        prev_d = q;
      end
      case (state_q)
        ST_IDLE: begin
          if (dec_onehot) begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        ST_ACQ: begin
          if (match) begin
            good_d = good_inc;
            if (good_inc == GW'(LOCK_CNT)) state_d = ST_LOCK;
          end else if (dec_onehot) begin
            good_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (!match) begin
            err_d   = 1'b1;
            good_d  = '0;
            state_d = dec_onehot ? ST_ACQ : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    locked_d = (state_d == ST_LOCK);

    // A clear coinciding with a new error leaves that error counted.
    if (clr_err) begin
      cnt_d = err_d ? ERR_W'(1) : '0;
    end else if (err_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      good_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign idx     = idx_q;
  assign valid   = valid_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_ring_count_monitor.sv
// Bench for ring_count_monitor: three instances (DIR=0, DIR=1, ERR_W=2)
// share one stimulus stream; a table of directed vectors, hand sequences for
// saturation and mid-cycle reset, then random traffic against a model.
module tb_ring_count_monitor;

  logic       c, r, en, clr_err;
  logic [3:0] q;

  logic [1:0] a_idx, b_idx, e_idx;
  logic       a_valid, b_valid, e_valid;
  logic       a_locked, b_locked, e_locked;
  logic       a_err, b_err, e_err;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] e_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ring_count_monitor #(.N(4), .DIR(0), .LOCK_CNT(2), .ERR_W(8)) dut_a (
    .c(c), .r(r), .en(en), .q(q), .clr_err(clr_err),
    .idx(a_idx), .valid(a_valid), .locked(a_locked), .err(a_err), .err_cnt(a_cnt));

  ring_count_monitor #(.N(4), .DIR(1), .LOCK_CNT(2), .ERR_W(8)) dut_b (
    .c(c), .r(r), .en(en), .q(q), .clr_err(clr_err),
    .idx(b_idx), .valid(b_valid), .locked(b_locked), .err(b_err), .err_cnt(b_cnt));

  ring_count_monitor #(.N(4), .DIR(0), .LOCK_CNT(2), .ERR_W(2)) dut_e (
    .c(c), .r(r), .en(en), .q(q), .clr_err(clr_err),
    .idx(e_idx), .valid(e_valid), .locked(e_locked), .err(e_err), .err_cnt(e_cnt));

  initial c = 1'b0;
  always #5 c = ~c;

  // ---------------- reference model (index arithmetic) ----------------
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;

  typedef struct {
    int st; int prev; int good; int idx;
    bit valid; bit locked; bit err; int cnt;
  } mdl_t;

  mdl_t ma, mb, me;

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = M_IDLE; m.prev = 0; m.good = 0; m.idx = 0;
    m.valid = 0; m.locked = 0; m.err = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit e, logic [3:0] qq, bit cl,
                                 int dir, int cmax);
    mdl_t n;
    bit   oh;
    bit   hit;
    int   qi;
    int   want;
    n  = m;
    qi = 0;
    oh = ($countones(qq) == 1);
    for (int i = 0; i < 4; i++) if (qq[i]) qi = i;
    want = (dir == 0) ? (m.prev + 1) % 4 : (m.prev + 3) % 4;
    hit  = oh && (qi == want);
    n.err = 0;
    if (e) begin
      n.valid = oh;
      if (oh) n.idx = qi;
      if (m.st == M_IDLE) begin
        if (oh) begin n.st = M_ACQ; n.prev = qi; n.good = 0; end
      end else if (m.st == M_ACQ) begin
        if (hit) begin
          n.good = m.good + 1; n.prev = qi;
          if (n.good == 2) n.st = M_LOCK;
        end else if (oh) begin
          n.good = 0; n.prev = qi;
        end else begin
          n.st = M_IDLE;
        end
      end else begin
        if (hit) n.prev = qi;
        else begin
          n.err = 1;
          if (oh) begin n.st = M_ACQ; n.good = 0; n.prev = qi; end
          else n.st = M_IDLE;
        end
      end
    end
    n.locked = (n.st == M_LOCK);
    if (cl) n.cnt = n.err ? 1 : 0;
    else if (n.err && n.cnt < cmax) n.cnt = n.cnt + 1;
    return n;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input int i, input int v,
                         input int l, input int e, input int cn);
    check({tag, " idx"},     i,  m.idx);
    check({tag, " valid"},   v,  int'(m.valid));
    check({tag, " locked"},  l,  int'(m.locked));
    check({tag, " err"},     e,  int'(m.err));
    check({tag, " err_cnt"}, cn, m.cnt);
  endtask

  task automatic cmp_all();
    cmp_dut("A", ma, int'(a_idx), int'(a_valid), int'(a_locked), int'(a_err), int'(a_cnt));
    cmp_dut("B", mb, int'(b_idx), int'(b_valid), int'(b_locked), int'(b_err), int'(b_cnt));
    cmp_dut("E", me, int'(e_idx), int'(e_valid), int'(e_locked), int'(e_err), int'(e_cnt));
  endtask

  // One clock: models step on the edge, outputs compared 1 ns later.
  task automatic cycle();
    @(posedge c);
    ma = mstep(ma, en, q, clr_err, 0, 255);
    mb = mstep(mb, en, q, clr_err, 1, 255);
    me = mstep(me, en, q, clr_err, 0, 3);
    #1;
    cmp_all();
  endtask

  task automatic apply(input bit e, input logic [3:0] qq, input bit cl);
    en = e; q = qq; clr_err = cl;
    cycle();
  endtask

  // Assert reset between edges and verify outputs clear without a clock.
  task automatic mid_reset();
    #2;
    r = 1'b0;
    #1;
    ma = mreset(); mb = mreset(); me = mreset();
    check("async rst A idx",    int'(a_idx),    0);
    check("async rst A valid",  int'(a_valid),  0);
    check("async rst A locked", int'(a_locked), 0);
    check("async rst A cnt",    int'(a_cnt),    0);
    cmp_all();
    #2;
    r = 1'b1;
  endtask

  function automatic logic [3:0] rl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [3:0] rr4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic en; logic [3:0] q; logic clr;
    logic [1:0] idx; logic valid; logic locked; logic err; logic [7:0] cnt;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [3:0] cur;
    logic [3:0] d1_q[5];
    int         d1_idx[5];
    int         d1_lk[5];
    int         sel;

    vecs[0]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 4'b1000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[7]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[8]  = '{1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[9]  = '{1'b1, 4'b0110, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[11] = '{1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[13] = '{1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[14] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[15] = '{1'b0, 4'b0110, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[16] = '{1'b0, 4'b1000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[17] = '{1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[18] = '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0};

    // Reset state.
    r = 1'b0; en = 1'b0; q = '0; clr_err = 1'b0;
    ma = mreset(); mb = mreset(); me = mreset();
    #12;
    check("reset A locked", int'(a_locked), 0);
    check("reset A valid",  int'(a_valid),  0);
    cmp_all();
    r = 1'b1;

    // Directed vectors: sequencing, lock, legal/illegal errors, hold, clear.
    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].en, vecs[i].q, vecs[i].clr);
      check($sformatf("vec%0d idx", i),    int'(a_idx),    int'(vecs[i].idx));
      check($sformatf("vec%0d valid", i),  int'(a_valid),  int'(vecs[i].valid));
      check($sformatf("vec%0d locked", i), int'(a_locked), int'(vecs[i].locked));
      check($sformatf("vec%0d err", i),    int'(a_err),    int'(vecs[i].err));
      check($sformatf("vec%0d err_cnt", i), int'(a_cnt),   int'(vecs[i].cnt));
    end

    // Disabled cycles with random bus contents: everything frozen.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      check("hold idx",    int'(a_idx),    2);
      check("hold locked", int'(a_locked), 1);
      check("hold err",    int'(a_err),    0);
    end

    // Five lock/error rounds: ERR_W=2 saturates at 3.
    cur = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, cur, 1'b0);
      check("stall err", int'(a_err), 1);
      cur = rl4(cur); apply(1'b1, cur, 1'b0);
      cur = rl4(cur); apply(1'b1, cur, 1'b0);
      check("relock", int'(a_locked), 1);
    end
    check("sat E err_cnt",  int'(e_cnt), 3);
    check("count A err_cnt", int'(a_cnt), 5);
    apply(1'b1, cur, 1'b1);
    check("clr+err A cnt", int'(a_cnt), 1);
    check("clr+err E cnt", int'(e_cnt), 1);
    apply(1'b0, 4'b0000, 1'b1);
    check("clr A cnt", int'(a_cnt), 0);
    check("clr E cnt", int'(e_cnt), 0);

    // Relock, then reset between edges; recover with three good samples.
    cur = rl4(cur); apply(1'b1, cur, 1'b0);
    cur = rl4(cur); apply(1'b1, cur, 1'b0);
    check("pre-reset locked", int'(a_locked), 1);
    mid_reset();
    apply(1'b1, 4'b0001, 1'b0);
    apply(1'b1, 4'b0010, 1'b0);
    apply(1'b1, 4'b0100, 1'b0);
    check("post-reset locked", int'(a_locked), 1);

    // DIR=1 sequence on the right-rotating instance.
    mid_reset();
    d1_q   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    d1_idx = '{3, 2, 1, 0, 3};
    d1_lk  = '{0, 0, 1, 1, 1};
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, d1_q[i], 1'b0);
      check($sformatf("dir1 s%0d idx", i),    int'(b_idx),    d1_idx[i]);
      check($sformatf("dir1 s%0d locked", i), int'(b_locked), d1_lk[i]);
      check($sformatf("dir1 s%0d err", i),    int'(b_err),    0);
    end

    // Random traffic, mostly well-formed rotations.
    cur = 4'b0001;
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] nq;
      sel = $urandom_range(0, 99);
      if (sel < 60)      nq = rl4(cur);
      else if (sel < 75) nq = rr4(cur);
      else if (sel < 82) nq = cur;
      else if (sel < 90) nq = 4'($urandom_range(0, 15));
      else               nq = 4'b0001 << $urandom_range(0, 3);
      if ($countones(nq) == 1) cur = nq;
      apply($urandom_range(0, 99) < 85, nq, $urandom_range(0, 99) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
